keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad. It strobes the columns one at a time and samples the rows. It debounces both press and release over several consecutive scan samples. Each confirmed keypress is delivered as a 4-bit key code with a valid/ack handshake. It sits between the keypad pins and the downstream consumer (display/arithmetic logic) and replaces free-running row/column sampling.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/keypad_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int KEY_W  = 4;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        PRESS   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Key code is 4*col + row, i.e. column in the upper bits.
    function automatic logic [KEY_W-1:0] key_encode(input logic [1:0] col_idx,
                                                    input logic [1:0] row_idx);
        return {col_idx, row_idx};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent level signals.
// Resets to all ones so an idle (pulled-up) input reads as inactive.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-strobing scan controller for a 4x4 matrix keypad with press and
// release debouncing and a valid/ack key handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// SCAN    | rotating the active column, looking for any low row on tick
// CONFIRM | column held, counting consecutive low samples of cand_row
// PRESS   | one cycle: deliver the key or flag overflow if unconsumed
// RELEASE | key held; counting consecutive high samples of cand_row
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] row_i,
    output logic [N_COLS-1:0] col_o,
    output logic [KEY_W-1:0]  key_code_o,
    output logic              key_valid_o,
    input  logic              key_ack_i,
    output logic              key_pressed_o,
    output logic              overflow_o
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_SCANS);

    logic [N_ROWS-1:0] row_s;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic              any_low;
    logic [1:0]        low_row;
    logic              cand_low;

    state_t            state;
    logic [1:0]        col_idx;
    logic [1:0]        cand_col;
    logic [1:0]        cand_row;
    logic [DW-1:0]     match_cnt;
    logic [DW-1:0]     rel_cnt;

    sync_2ff #(.W(N_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_i),
        .q   (row_s)
    );

    assign tick     = (tick_cnt == TICK_LAST);
    assign cand_low = ~row_s[cand_row];

    // Free-running sample-period counter; wraps after SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Lowest-index active row wins when several rows are low.
    always_comb begin
        any_low = ~&row_s;
        low_row = 2'd0;
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (!row_s[r]) begin
                low_row = 2'(r);
            end
        end
    end

    // Scan/debounce FSM plus the key handshake register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SCAN;
            col_idx       <= 2'd0;
            col_o         <= 4'b1110;
            cand_col      <= 2'd0;
            cand_row      <= 2'd0;
            match_cnt     <= '0;
            rel_cnt       <= '0;
            key_code_o    <= '0;
            key_valid_o   <= 1'b0;
            key_pressed_o <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            overflow_o <= 1'b0;
            if (key_ack_i && key_valid_o) begin
                key_valid_o <= 1'b0;
            end

            case (state)
                SCAN: begin
                    if (tick) begin
                        if (any_low) begin
                            cand_col  <= col_idx;
                            cand_row  <= low_row;
                            match_cnt <= DW'(1);
                            state     <= (DEBOUNCE_SCANS == 1) ? PRESS : CONFIRM;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col_o   <= {col_o[N_COLS-2:0], col_o[N_COLS-1]};
                        end
                    end
                end

                CONFIRM: begin
                    if (tick) begin
                        if (cand_low) begin
                            if (match_cnt != DB_LAST) begin
                                match_cnt <= match_cnt + DW'(1);
                            end
                            if (match_cnt + DW'(1) == DB_LAST) begin
                                state <= PRESS;
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_idx + 2'd1;
                            col_o   <= {col_o[N_COLS-2:0], col_o[N_COLS-1]};
                        end
                    end
                end

                PRESS: begin
                    // A same-cycle ack frees the holding register for the new key.
                    if (!key_valid_o || key_ack_i) begin
                        key_code_o  <= key_encode(cand_col, cand_row);
                        key_valid_o <= 1'b1;
                    end else begin
                        overflow_o <= 1'b1;
                    end
                    key_pressed_o <= 1'b1;
                    rel_cnt       <= '0;
                    state         <= RELEASE;
                end

                RELEASE: begin
                    if (tick) begin
                        if (cand_low) begin
                            rel_cnt <= '0;
                        end else if (rel_cnt + DW'(1) == DB_LAST) begin
                            rel_cnt       <= DB_LAST;
                            key_pressed_o <= 1'b0;
                            state         <= SCAN;
                            col_idx       <= col_idx + 2'd1;
                            col_o         <= {col_o[N_COLS-2:0], col_o[N_COLS-1]};
                        end else begin
                            rel_cnt <= rel_cnt + DW'(1);
                        end
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: directed scenarios followed by
// randomized press/ack rounds scored against a key-level model.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV = 8;
    localparam int DB       = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_ack_i = 1'b0;
    logic       key_pressed_o;
    logic       overflow_o;

    logic [15:0] keys = '0;
    int edges    = 0;
    int ovf_seen = 0;
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
        .clk           (clk),
        .rst           (rst),
        .row_i         (row_i),
        .col_o         (col_o),
        .key_code_o    (key_code_o),
        .key_valid_o   (key_valid_o),
        .key_ack_i     (key_ack_i),
        .key_pressed_o (key_pressed_o),
        .overflow_o    (overflow_o)
    );

    // Passive key matrix: a held key pulls its row low while its column is strobed.
    always_comb begin
        row_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && (col_o[c] === 1'b0)) begin
                    row_i[r] = 1'b0;
                end
            end
        end
    end

    // Edges since reset release; sample ticks land on multiples of SCAN_DIV.
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    // Count overflow pulses seen on the output.
    always @(negedge clk) begin
        if (overflow_o === 1'b1) ovf_seen <= ovf_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c[1:0]);
    endfunction

    function automatic int ceil_tick(input int x);
        return ((x + SCAN_DIV - 1) / SCAN_DIV) * SCAN_DIV;
    endfunction

    task automatic wait_to(input int n);
        while (edges < n) @(negedge clk);
    endtask

    // Wait (bounded) for the cycle just after column c becomes strobed.
    task automatic find_window(input int c, output bit ok);
        int start;
        start = edges;
        ok = 1'b0;
        while (edges < start + 64) begin
            if (col_o === col_pat(c) && (edges % SCAN_DIV) == 1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("window_found", 32'(ok), 32'd1);
    endtask

    // Press key (c,r) at the start of its column window; returns the edge
    // after which key_pressed_o/key_valid_o are due.
    task automatic press_at(input int c, input int r, output int v_edge);
        bit ok;
        find_window(c, ok);
        keys[c*4+r] = 1'b1;
        v_edge = ceil_tick(edges + 3) + SCAN_DIV * (DB - 1) + 1;
    endtask

    // Release every key; returns the edge after which key_pressed_o falls.
    task automatic release_all(output int f_edge);
        keys = '0;
        f_edge = ceil_tick(edges + 3) + SCAN_DIV * (DB - 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col"},   32'(col_o),         32'h E);
        check({tag, "_code"},  32'(key_code_o),    32'h0);
        check({tag, "_valid"}, 32'(key_valid_o),   32'h0);
        check({tag, "_press"}, 32'(key_pressed_o), 32'h0);
        check({tag, "_ovf"},   32'(overflow_o),    32'h0);
    endtask

    initial begin
        int v, f, e0, ovf_exp;
        bit ok;
        logic [3:0] m_code;
        logic       m_valid;

        ovf_exp = 0;
        m_code  = 4'h0;
        m_valid = 1'b0;

        // Reset, then idle scanning every SCAN_DIV cycles.
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            wait_to(n);
            check("idle_col", 32'(col_o), 32'(col_pat((n / SCAN_DIV) % 4)));
            check("idle_valid", 32'(key_valid_o), 32'd0);
        end

        // Clean press of col 2 / row 1.
        press_at(2, 1, v);
        wait_to(v - 1);
        check("clean_early_valid", 32'(key_valid_o), 32'd0);
        check("clean_early_press", 32'(key_pressed_o), 32'd0);
        wait_to(v);
        check("clean_valid", 32'(key_valid_o), 32'd1);
        check("clean_code", 32'(key_code_o), 32'd9);
        check("clean_press", 32'(key_pressed_o), 32'd1);
        wait_to(v + 20);
        check("clean_hold_col", 32'(col_o), 32'h B);
        check("clean_hold_valid", 32'(key_valid_o), 32'd1);
        key_ack_i = 1'b1;
        @(negedge clk);
        key_ack_i = 1'b0;
        check("clean_ack_clear", 32'(key_valid_o), 32'd0);
        key_ack_i = 1'b1;
        @(negedge clk);
        key_ack_i = 1'b0;
        check("ack_idle_valid", 32'(key_valid_o), 32'd0);
        release_all(f);
        wait_to(f - 1);
        check("clean_rel_early", 32'(key_pressed_o), 32'd1);
        wait_to(f);
        check("clean_rel", 32'(key_pressed_o), 32'd0);
        check("clean_rel_col", 32'(col_o), 32'h7);

        // Bounce: col 1 / row 3 alternates low/high on successive samples.
        for (int k = 0; k < 12; k++) begin
            wait_to((edges / SCAN_DIV + 1) * SCAN_DIV + 4);
            keys[7] = ~keys[7];
            check("bounce_valid", 32'(key_valid_o), 32'd0);
            check("bounce_press", 32'(key_pressed_o), 32'd0);
        end
        keys = '0;
        find_window(0, ok);
        e0 = edges;
        wait_to(e0 + SCAN_DIV);
        check("bounce_resume", 32'(col_o), 32'h D);
        check("bounce_resume_valid", 32'(key_valid_o), 32'd0);

        // Overflow: code 0 then code 15 without ack.
        press_at(0, 0, v);
        wait_to(v);
        check("ovf_first_code", 32'(key_code_o), 32'd0);
        check("ovf_first_valid", 32'(key_valid_o), 32'd1);
        check("ovf_first_pulse", 32'(overflow_o), 32'd0);
        release_all(f);
        wait_to(f);
        press_at(3, 3, v);
        wait_to(v);
        check("ovf_code_kept", 32'(key_code_o), 32'd0);
        check("ovf_pulse", 32'(overflow_o), 32'd1);
        ovf_exp++;
        wait_to(v + 1);
        check("ovf_pulse_end", 32'(overflow_o), 32'd0);
        check("ovf_count", 32'(ovf_seen), 32'(ovf_exp));
        release_all(f);
        wait_to(f);
        // Same again with ack in the PRESS cycle.
        press_at(3, 3, v);
        wait_to(v - 1);
        key_ack_i = 1'b1;
        wait_to(v);
        check("ackpress_code", 32'(key_code_o), 32'd15);
        check("ackpress_valid", 32'(key_valid_o), 32'd1);
        check("ackpress_ovf", 32'(overflow_o), 32'd0);
        key_ack_i = 1'b0;
        wait_to(v + 1);
        check("ackpress_count", 32'(ovf_seen), 32'(ovf_exp));
        release_all(f);
        wait_to(f);
        key_ack_i = 1'b1;
        @(negedge clk);
        key_ack_i = 1'b0;

        // Multi-key in column 1, rows 0 and 2; release row 2 first.
        press_at(1, 0, v);
        keys[1*4+2] = 1'b1;
        wait_to(v);
        check("multi_code", 32'(key_code_o), 32'd4);
        check("multi_press", 32'(key_pressed_o), 32'd1);
        keys[1*4+2] = 1'b0;
        wait_to(v + 4 * SCAN_DIV);
        check("multi_row2_up", 32'(key_pressed_o), 32'd1);
        release_all(f);
        wait_to(f - 1);
        check("multi_rel_early", 32'(key_pressed_o), 32'd1);
        wait_to(f);
        check("multi_rel", 32'(key_pressed_o), 32'd0);
        key_ack_i = 1'b1;
        @(negedge clk);
        key_ack_i = 1'b0;

        // Reset while a key is held in RELEASE.
        press_at(2, 2, v);
        wait_to(v + 4);
        check("midrst_press", 32'(key_pressed_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        keys = '0;
        @(negedge clk);
        rst = 1'b0;
        wait_to(SCAN_DIV - 1);
        check("postrst_col0", 32'(col_o), 32'h E);
        wait_to(SCAN_DIV);
        check("postrst_col1", 32'(col_o), 32'h D);

        // Randomized rounds: mode 0 acks after release, 1 never acks,
        // 2 acks in the PRESS cycle.
        for (int k = 0; k < 10; k++) begin
            int c, r, mode, hold;
            c    = $urandom_range(0, 3);
            r    = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            press_at(c, r, v);
            wait_to(v - 1);
            check("rnd_early_press", 32'(key_pressed_o), 32'd0);
            if (mode == 2) key_ack_i = 1'b1;
            wait_to(v);
            if (!m_valid || mode == 2) begin
                m_code  = 4'(4 * c + r);
                m_valid = 1'b1;
            end else begin
                ovf_exp++;
            end
            check("rnd_code", 32'(key_code_o), 32'(m_code));
            check("rnd_valid", 32'(key_valid_o), 32'(m_valid));
            check("rnd_press", 32'(key_pressed_o), 32'd1);
            key_ack_i = 1'b0;
            wait_to(v + 1);
            check("rnd_ovf_count", 32'(ovf_seen), 32'(ovf_exp));
            wait_to(v + 1 + SCAN_DIV * hold);
            release_all(f);
            wait_to(f - 1);
            check("rnd_rel_early", 32'(key_pressed_o), 32'd1);
            wait_to(f);
            check("rnd_rel", 32'(key_pressed_o), 32'd0);
            if (mode == 0) begin
                key_ack_i = 1'b1;
                @(negedge clk);
                key_ack_i = 1'b0;
                m_valid = 1'b0;
                check("rnd_ack_clear", 32'(key_valid_o), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
